l1_l2c_arb: RTL and testbench

Arbitrates the single L2C request port between the instruction L1 (IL1) and data L1 (DL1) caches of one MBS core. It owns the port for the whole transaction, from request through final data beat or TLB fault, and routes responses back to the owner only. It also fans out L2C invalidations to both L1s and merges their acknowledgements.

---
 rtl/mbs_pkg.sv | 23 ++
 rtl/l1_l2c_inv_merge.sv | 44 ++++
 rtl/l1_l2c_arb.sv | 177 +++++++++++++++++
 tb/tb_l1_l2c_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbs_pkg.sv
// Shared MBS core definitions: L1 request flag bit positions, L2C arbiter
// state/owner encodings and the default cache line length in beats.
package mbs_pkg;

    localparam int unsigned FLAG_CACHEABLE = 1;
    localparam int unsigned FLAG_WRITE     = 0;
    localparam int unsigned LINE_BEATS_DEF = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    typedef enum logic {
        OwnIl1 = 1'b0,
        OwnDl1 = 1'b1
    } arb_own_e;

    function automatic logic is_cacheable_read(input logic [1:0] flags);
        return flags[FLAG_CACHEABLE] & ~flags[FLAG_WRITE];
    endfunction

endpackage

// File: rtl/l1_l2c_inv_merge.sv
// Fans L2C invalidations out to both L1 caches and merges their acknowledgements
// into one pulse once both have answered, in the same cycle or in any order.
module l1_l2c_inv_merge (
    input  logic        clk_mc,
    input  logic        rst_mc_n,
    input  logic        i_l2c_inv_req,
    input  logic [31:0] i_l2c_inv_adr,
    output logic        o_l2c_inv_ack,
    output logic        o_il1_inv_req,
    output logic        o_dl1_inv_req,
    output logic [31:0] o_l1_inv_adr,
    input  logic        i_il1_inv_ack,
    input  logic        i_dl1_inv_ack
);

    logic r_il1_ack;
    logic r_dl1_ack;
    logic w_il1_seen;
    logic w_dl1_seen;
    logic w_both;

    always_comb begin
        w_il1_seen = r_il1_ack | i_il1_inv_ack;
        w_dl1_seen = r_dl1_ack | i_dl1_inv_ack;
        w_both     = w_il1_seen & w_dl1_seen;
    end

    // Sticky acks drop on the merged pulse so the next invalidation starts clean.
    always_ff @(posedge clk_mc) begin
        if (!rst_mc_n) begin
            r_il1_ack <= 1'b0;
            r_dl1_ack <= 1'b0;
        end else begin
            r_il1_ack <= w_il1_seen & ~w_both;
            r_dl1_ack <= w_dl1_seen & ~w_both;
        end
    end

    assign o_l2c_inv_ack = w_both;
    assign o_il1_inv_req = i_l2c_inv_req;
    assign o_dl1_inv_req = i_l2c_inv_req;
    assign o_l1_inv_adr  = i_l2c_inv_adr;

endmodule

// File: rtl/l1_l2c_arb.sv
// Arbitrates the L2C request port between IL1 and DL1 and steers responses to the owner.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise DL1 has fixed priority.
module l1_l2c_arb
    import mbs_pkg::*;
#(
    parameter int unsigned LINE_BEATS = LINE_BEATS_DEF
) (
    input  logic        clk_mc,
    input  logic        rst_mc_n,
    input  logic [31:0] i_il1_adr,
    input  logic [1:0]  i_il1_flags,
    input  logic        i_il1_valid,
    output logic        o_il1_stall,
    output logic        o_il1_rdata_valid,
    output logic        o_il1_tlb_fault,
    input  logic [31:0] i_dl1_adr,
    input  logic [1:0]  i_dl1_flags,
    input  logic        i_dl1_valid,
    output logic        o_dl1_stall,
    output logic        o_dl1_rdata_valid,
    output logic        o_dl1_tlb_fault,
    output logic [31:0] o_l1_rdata,
    output logic [31:0] o_l2c_adr,
    output logic [1:0]  o_l2c_flags,
    output logic        o_l2c_valid,
    input  logic [31:0] i_l2c_rdata,
    input  logic        i_l2c_rdata_valid,
    input  logic        i_l2c_tlb_fault,
    input  logic        i_l2c_stall,
    input  logic        i_l2c_inv_req,
    input  logic [31:0] i_l2c_inv_adr,
    output logic        o_l2c_inv_ack,
    output logic        o_il1_inv_req,
    output logic        o_dl1_inv_req,
    output logic [31:0] o_l1_inv_adr,
    input  logic        i_il1_inv_ack,
    input  logic        i_dl1_inv_ack
);

    localparam int unsigned       BCNT_W    = $clog2(LINE_BEATS);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(LINE_BEATS - 1);

    arb_state_e        r_state;
    arb_state_e        w_state_d;
    arb_own_e          r_own;
    arb_own_e          w_own_d;
    logic              r_acc;
    logic              w_acc_d;
    logic [BCNT_W-1:0] r_bcnt;
    logic [BCNT_W-1:0] w_bcnt_d;
    logic              r_full;
    logic              w_full_d;
    logic              r_l2c_valid;
    logic              w_l2c_valid_d;
    logic [31:0]       r_l2c_adr;
    logic [31:0]       w_l2c_adr_d;
    logic [1:0]        r_l2c_flags;
    logic [1:0]        w_l2c_flags_d;

    logic w_busy;
    logic w_accept;
    logic w_beat;
    logic w_fault;
    logic w_last_beat;
    logic w_got_all;
    logic w_done;
    logic w_tie_dl1;
    logic w_gnt_dl1;

    always_comb begin
        w_busy   = (r_state == StBusy);
        w_accept = w_busy & r_l2c_valid & ~i_l2c_stall;
        w_beat   = w_busy & i_l2c_rdata_valid;
        w_fault  = w_busy & i_l2c_tlb_fault;
        // Uncached reads finish on their single beat; line fills on the counter wrap.
        w_last_beat = w_beat & (is_cacheable_read(r_l2c_flags) ? (r_bcnt == BCNT_LAST) : 1'b1);
        // r_full remembers a completed beat set when beats overtake the accept.
        w_got_all = r_l2c_flags[FLAG_WRITE] | r_full | w_last_beat;
        w_done    = w_busy & (((r_acc | w_accept) & w_got_all) | w_fault);
`ifdef ARB_RR_EN
        w_tie_dl1 = (r_own == OwnIl1);
`else
        w_tie_dl1 = 1'b1;
`endif
        w_gnt_dl1 = i_dl1_valid & (~i_il1_valid | w_tie_dl1);
    end

    always_comb begin
        w_state_d     = r_state;
        w_own_d       = r_own;
        w_acc_d       = r_acc;
        w_bcnt_d      = r_bcnt;
        w_full_d      = r_full;
        w_l2c_valid_d = r_l2c_valid;
        w_l2c_adr_d   = r_l2c_adr;
        w_l2c_flags_d = r_l2c_flags;
        unique case (r_state)
            StIdle: begin
                if (i_il1_valid | i_dl1_valid) begin
                    w_state_d     = StBusy;
                    w_own_d       = w_gnt_dl1 ? OwnDl1 : OwnIl1;
                    w_l2c_valid_d = 1'b1;
                    w_l2c_adr_d   = (w_gnt_dl1 ? i_dl1_adr : i_il1_adr) & 32'hFFFF_FFFC;
                    w_l2c_flags_d = w_gnt_dl1 ? i_dl1_flags : i_il1_flags;
                    w_acc_d       = 1'b0;
                    w_bcnt_d      = '0;
                    w_full_d      = 1'b0;
                end
            end
            StBusy: begin
                if (w_beat) begin
                    w_bcnt_d = r_bcnt + BCNT_W'(1);
                    w_full_d = r_full | w_last_beat;
                end
                if (w_accept) begin
                    w_acc_d       = 1'b1;
                    w_l2c_valid_d = 1'b0;
                end
                if (w_done) begin
                    w_state_d     = StIdle;
                    w_acc_d       = 1'b0;
                    w_bcnt_d      = '0;
                    w_full_d      = 1'b0;
                    w_l2c_valid_d = 1'b0;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_mc) begin
        if (!rst_mc_n) begin
            r_state     <= StIdle;
            r_own       <= OwnIl1;
            r_acc       <= 1'b0;
            r_bcnt      <= '0;
            r_full      <= 1'b0;
            r_l2c_valid <= 1'b0;
            r_l2c_adr   <= '0;
            r_l2c_flags <= '0;
        end else begin
            r_state     <= w_state_d;
            r_own       <= w_own_d;
            r_acc       <= w_acc_d;
            r_bcnt      <= w_bcnt_d;
            r_full      <= w_full_d;
            r_l2c_valid <= w_l2c_valid_d;
            r_l2c_adr   <= w_l2c_adr_d;
            r_l2c_flags <= w_l2c_flags_d;
        end
    end

    assign o_il1_stall       = ~(w_accept & (r_own == OwnIl1));
    assign o_dl1_stall       = ~(w_accept & (r_own == OwnDl1));
    assign o_il1_rdata_valid = w_beat & (r_own == OwnIl1);
    assign o_dl1_rdata_valid = w_beat & (r_own == OwnDl1);
    assign o_il1_tlb_fault   = w_fault & (r_own == OwnIl1);
    assign o_dl1_tlb_fault   = w_fault & (r_own == OwnDl1);
    assign o_l1_rdata        = i_l2c_rdata;
    assign o_l2c_adr         = r_l2c_adr;
    assign o_l2c_flags       = r_l2c_flags;
    assign o_l2c_valid       = r_l2c_valid;

    l1_l2c_inv_merge u_inv_merge (
        .clk_mc        (clk_mc),
        .rst_mc_n      (rst_mc_n),
        .i_l2c_inv_req (i_l2c_inv_req),
        .i_l2c_inv_adr (i_l2c_inv_adr),
        .o_l2c_inv_ack (o_l2c_inv_ack),
        .o_il1_inv_req (o_il1_inv_req),
        .o_dl1_inv_req (o_dl1_inv_req),
        .o_l1_inv_adr  (o_l1_inv_adr),
        .i_il1_inv_ack (i_il1_inv_ack),
        .i_dl1_inv_ack (i_dl1_inv_ack)
    );

endmodule

// File: tb/tb_l1_l2c_arb.sv
// Bench for l1_l2c_arb: transaction-level reference model checked every cycle,
// a directed vector table, hand-written corner sequences and randomized traffic.
module tb_l1_l2c_arb;

    localparam int LB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] il1_adr, dl1_adr, l2c_rdata, inv_adr;
    logic [1:0]  il1_flags, dl1_flags;
    logic        il1_valid, dl1_valid, l2c_rv, l2c_flt, l2c_stall;
    logic        inv_req, il1_ack, dl1_ack;

    logic        o_il1_stall, o_il1_rv, o_il1_flt, o_dl1_stall, o_dl1_rv, o_dl1_flt;
    logic [31:0] o_l1_rdata, o_l2c_adr, o_l1_inv_adr;
    logic [1:0]  o_l2c_flags;
    logic        o_l2c_valid, o_l2c_inv_ack, o_il1_inv_req, o_dl1_inv_req;

    l1_l2c_arb #(.LINE_BEATS(LB)) dut (
        .clk_mc            (clk),
        .rst_mc_n          (rst_n),
        .i_il1_adr         (il1_adr),
        .i_il1_flags       (il1_flags),
        .i_il1_valid       (il1_valid),
        .o_il1_stall       (o_il1_stall),
        .o_il1_rdata_valid (o_il1_rv),
        .o_il1_tlb_fault   (o_il1_flt),
        .i_dl1_adr         (dl1_adr),
        .i_dl1_flags       (dl1_flags),
        .i_dl1_valid       (dl1_valid),
        .o_dl1_stall       (o_dl1_stall),
        .o_dl1_rdata_valid (o_dl1_rv),
        .o_dl1_tlb_fault   (o_dl1_flt),
        .o_l1_rdata        (o_l1_rdata),
        .o_l2c_adr         (o_l2c_adr),
        .o_l2c_flags       (o_l2c_flags),
        .o_l2c_valid       (o_l2c_valid),
        .i_l2c_rdata       (l2c_rdata),
        .i_l2c_rdata_valid (l2c_rv),
        .i_l2c_tlb_fault   (l2c_flt),
        .i_l2c_stall       (l2c_stall),
        .i_l2c_inv_req     (inv_req),
        .i_l2c_inv_adr     (inv_adr),
        .o_l2c_inv_ack     (o_l2c_inv_ack),
        .o_il1_inv_req     (o_il1_inv_req),
        .o_dl1_inv_req     (o_dl1_inv_req),
        .o_l1_inv_adr      (o_l1_inv_adr),
        .i_il1_inv_ack     (il1_ack),
        .i_dl1_inv_ack     (dl1_ack)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction described by owner, accept seen,
    // beats received so far and beats the request needs.
    bit          m_known = 0;
    bit          m_busy, m_acc, m_lval, m_ai, m_ad;
    int          m_own, m_beats, m_need;
    logic [31:0] m_ladr;
    logic [1:0]  m_lflags;

    int c_irv = 0, c_drv = 0, c_iflt = 0, c_dflt = 0, c_inv = 0;
    logic        s_lval, s_ist, s_dst, s_irv, s_drv, s_iflt, s_dflt, s_inv, s_ireq;
    logic [31:0] s_adr;
    logic [1:0]  s_flags;

    task automatic model_compare();
        bit owner_go;
        owner_go = m_busy && m_lval && !l2c_stall;
        chk1 ("model l2c_valid", o_l2c_valid, m_lval);
        chk32("model l2c_adr", o_l2c_adr, m_ladr);
        chk32("model l2c_flags", 32'(o_l2c_flags), 32'(m_lflags));
        chk1 ("model il1_stall", o_il1_stall, !(owner_go && m_own == 0));
        chk1 ("model dl1_stall", o_dl1_stall, !(owner_go && m_own == 1));
        chk1 ("model il1_rdata_valid", o_il1_rv, m_busy && m_own == 0 && l2c_rv);
        chk1 ("model dl1_rdata_valid", o_dl1_rv, m_busy && m_own == 1 && l2c_rv);
        chk1 ("model il1_tlb_fault", o_il1_flt, m_busy && m_own == 0 && l2c_flt);
        chk1 ("model dl1_tlb_fault", o_dl1_flt, m_busy && m_own == 1 && l2c_flt);
        chk32("model l1_rdata", o_l1_rdata, l2c_rdata);
        chk1 ("model il1_inv_req", o_il1_inv_req, inv_req);
        chk1 ("model dl1_inv_req", o_dl1_inv_req, inv_req);
        chk32("model l1_inv_adr", o_l1_inv_adr, inv_adr);
        chk1 ("model l2c_inv_ack", o_l2c_inv_ack, (m_ai || il1_ack) && (m_ad || dl1_ack));
    endtask

    task automatic model_step();
        bit acc_now, si, sd;
        int win;
        logic [1:0] fl;
        if (!rst_n) begin
            m_known = 1; m_busy = 0; m_own = 0; m_acc = 0; m_beats = 0; m_need = 0;
            m_lval = 0; m_ladr = '0; m_lflags = '0; m_ai = 0; m_ad = 0;
            return;
        end
        if (!m_busy) begin
            if (il1_valid || dl1_valid) begin
`ifdef ARB_RR_EN
                win = (il1_valid && dl1_valid) ? 1 - m_own : (dl1_valid ? 1 : 0);
`else
                win = dl1_valid ? 1 : 0;
`endif
                fl       = win ? dl1_flags : il1_flags;
                m_busy   = 1;
                m_own    = win;
                m_lval   = 1;
                m_ladr   = (win ? dl1_adr : il1_adr) & 32'hFFFF_FFFC;
                m_lflags = fl;
                m_acc    = 0;
                m_beats  = 0;
                m_need   = fl[0] ? 0 : (fl[1] ? LB : 1);
            end
        end else begin
            acc_now = m_lval && !l2c_stall;
            if (l2c_rv) m_beats++;
            if (l2c_flt || ((m_acc || acc_now) && m_beats >= m_need)) begin
                m_busy = 0; m_lval = 0; m_acc = 0; m_beats = 0;
            end else if (acc_now) begin
                m_acc = 1; m_lval = 0;
            end
        end
        si = m_ai || il1_ack;
        sd = m_ad || dl1_ack;
        m_ai = si && !(si && sd);
        m_ad = sd && !(si && sd);
    endtask

    // One clock: inputs already driven; sample at the falling edge, then advance.
    task automatic cyc();
        @(negedge clk);
        if (m_known) model_compare();
        s_lval = o_l2c_valid; s_ist = o_il1_stall; s_dst = o_dl1_stall;
        s_irv = o_il1_rv; s_drv = o_dl1_rv; s_iflt = o_il1_flt; s_dflt = o_dl1_flt;
        s_inv = o_l2c_inv_ack; s_ireq = o_il1_inv_req; s_adr = o_l2c_adr; s_flags = o_l2c_flags;
        if (o_il1_rv) c_irv++;
        if (o_dl1_rv) c_drv++;
        if (o_il1_flt) c_iflt++;
        if (o_dl1_flt) c_dflt++;
        if (o_l2c_inv_ack) c_inv++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1; il1_valid = 0; dl1_valid = 0; il1_flags = 0; dl1_flags = 0;
        l2c_rv = 0; l2c_flt = 0; l2c_stall = 0; inv_req = 0; il1_ack = 0; dl1_ack = 0;
    endtask

    typedef struct {
        bit iv; bit dv; logic [1:0] ifl; logic [1:0] dfl; bit stall; bit rv;
        bit e_lval; bit e_ist; bit e_dst; bit e_irv; bit e_drv; logic [31:0] e_adr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int base0, base1, exp_adr;
        bit pend_i, pend_d;

        // IL1 uncached read stalled 2 cycles, one beat, then a DL1 write accepted at once.
        tbl[0] = '{1, 0, 2'b00, 2'b00, 1, 0,  0, 1, 1, 0, 0, 32'h0000_0000};
        tbl[1] = '{1, 0, 2'b00, 2'b00, 1, 0,  1, 1, 1, 0, 0, 32'h1000_0004};
        tbl[2] = '{1, 0, 2'b00, 2'b00, 1, 0,  1, 1, 1, 0, 0, 32'h1000_0004};
        tbl[3] = '{1, 0, 2'b00, 2'b00, 0, 0,  1, 0, 1, 0, 0, 32'h1000_0004};
        tbl[4] = '{0, 0, 2'b00, 2'b00, 0, 0,  0, 1, 1, 0, 0, 32'h1000_0004};
        tbl[5] = '{0, 0, 2'b00, 2'b00, 0, 1,  0, 1, 1, 1, 0, 32'h1000_0004};
        tbl[6] = '{0, 0, 2'b00, 2'b00, 0, 1,  0, 1, 1, 0, 0, 32'h1000_0004};
        tbl[7] = '{0, 1, 2'b00, 2'b01, 0, 0,  0, 1, 1, 0, 0, 32'h1000_0004};
        tbl[8] = '{0, 1, 2'b00, 2'b01, 0, 0,  1, 1, 0, 0, 0, 32'h2000_0004};
        tbl[9] = '{0, 0, 2'b00, 2'b01, 0, 0,  0, 1, 1, 0, 0, 32'h2000_0004};

        idle_inputs();
        rst_n = 0; il1_adr = 0; dl1_adr = 0; l2c_rdata = 32'hDEAD_BEEF; inv_adr = 0;
        repeat (2) cyc();
        rst_n = 1;
        cyc();
        chk1 ("reset l2c_valid", s_lval, 1'b0);
        chk32("reset l2c_adr", s_adr, 32'h0);
        chk32("reset l2c_flags", 32'(s_flags), 32'h0);
        chk1 ("reset il1_stall", s_ist, 1'b1);
        chk1 ("reset dl1_stall", s_dst, 1'b1);
        chk1 ("reset inv_ack", s_inv, 1'b0);

        il1_adr = 32'h1000_0004; dl1_adr = 32'h2000_0007;
        for (int i = 0; i < 10; i++) begin
            il1_valid = tbl[i].iv; dl1_valid = tbl[i].dv;
            il1_flags = tbl[i].ifl; dl1_flags = tbl[i].dfl;
            l2c_stall = tbl[i].stall; l2c_rv = tbl[i].rv;
            cyc();
            chk1 ($sformatf("vec%0d l2c_valid", i), s_lval, tbl[i].e_lval);
            chk1 ($sformatf("vec%0d il1_stall", i), s_ist, tbl[i].e_ist);
            chk1 ($sformatf("vec%0d dl1_stall", i), s_dst, tbl[i].e_dst);
            chk1 ($sformatf("vec%0d il1_rdata_valid", i), s_irv, tbl[i].e_irv);
            chk1 ($sformatf("vec%0d dl1_rdata_valid", i), s_drv, tbl[i].e_drv);
            chk32($sformatf("vec%0d l2c_adr", i), s_adr, tbl[i].e_adr);
        end

        // DL1 line fill, 3 beats before accept; IL1 request during the final beat.
        idle_inputs();
        dl1_valid = 1; dl1_flags = 2'b10; dl1_adr = 32'h3000_0040;
        base0 = c_drv; base1 = c_irv;
        cyc();
        l2c_stall = 1; l2c_rv = 1;
        repeat (3) cyc();
        chk1("fill dl1 stalled before accept", s_dst, 1'b1);
        l2c_stall = 0; l2c_rv = 0;
        cyc();
        chk1("fill dl1 stall low on accept", s_dst, 1'b0);
        dl1_valid = 0; l2c_rv = 1;
        repeat (4) cyc();
        il1_valid = 1; il1_flags = 2'b01; il1_adr = 32'h4000_0008;
        cyc();
        l2c_rv = 0;
        cyc();
        chk1("fill no grant on done cycle", s_lval, 1'b0);
        cyc();
        chk1 ("fill il1 granted after done", s_lval, 1'b1);
        chk32("fill il1 adr", s_adr, 32'h4000_0008);
        il1_valid = 0;
        cyc();
        chk32("fill dl1 beat count", c_drv - base0, 8);
        chk32("fill il1 no strobes", c_irv - base1, 0);

        // Two simultaneous requests, twice.
        idle_inputs();
        il1_adr = 32'h5000_0000; dl1_adr = 32'h6000_0000;
        il1_flags = 2'b01; dl1_flags = 2'b01; il1_valid = 1; dl1_valid = 1;
        cyc();
        cyc();
        chk32("tie1 winner", s_adr, 32'h6000_0000);
        chk1 ("tie1 loser stalled", s_ist, 1'b1);
        cyc();
        cyc();
`ifdef ARB_RR_EN
        exp_adr = 32'h5000_0000;
`else
        exp_adr = 32'h6000_0000;
`endif
        chk32("tie2 winner", s_adr, exp_adr);
        il1_valid = 0; dl1_valid = 0;
        repeat (2) cyc();

        // TLB fault on the third beat slot of an IL1 line fill.
        idle_inputs();
        il1_valid = 1; il1_flags = 2'b10; il1_adr = 32'h7000_0010;
        base0 = c_iflt;
        cyc();
        cyc();
        il1_valid = 0; l2c_rv = 1;
        repeat (2) cyc();
        l2c_rv = 0; l2c_flt = 1;
        cyc();
        chk1("fault il1 pulse", s_iflt, 1'b1);
        chk1("fault dl1 quiet", s_dflt, 1'b0);
        l2c_flt = 0;
        chk32("fault count", c_iflt - base0, 1);
        // Fresh line fill must need all beats again.
        il1_valid = 1;
        cyc();
        chk1("fault idle after fault", s_lval, 1'b0);
        cyc();
        il1_valid = 0; l2c_rv = 1;
        repeat (6) cyc();
        dl1_valid = 1; dl1_flags = 2'b01; dl1_adr = 32'h7100_0000;
        cyc();
        cyc();
        chk1("fault refill still busy at beat 8", s_lval, 1'b0);
        l2c_rv = 0;
        cyc();
        cyc();
        chk1("fault refill then dl1 granted", s_lval, 1'b1);
        dl1_valid = 0;
        cyc();

        // Invalidation: IL1 acks at cycle 2, DL1 at cycle 5, then simultaneous acks.
        idle_inputs();
        inv_req = 1; inv_adr = 32'h8000_1000;
        base0 = c_inv;
        cyc();
        chk1("inv fan-out", s_ireq, 1'b1);
        cyc();
        il1_ack = 1;
        cyc();
        il1_ack = 0;
        repeat (2) cyc();
        dl1_ack = 1;
        cyc();
        chk1("inv ack on second ack", s_inv, 1'b1);
        dl1_ack = 0;
        chk32("inv single pulse", c_inv - base0, 1);
        il1_ack = 1; dl1_ack = 1;
        cyc();
        chk1("inv simultaneous ack", s_inv, 1'b1);
        il1_ack = 0; dl1_ack = 0;
        cyc();
        chk1("inv ack not repeated", s_inv, 1'b0);
        inv_req = 0;

        // Reset during beat 4 of a DL1 line fill.
        idle_inputs();
        dl1_valid = 1; dl1_flags = 2'b10; dl1_adr = 32'h9000_0000;
        base0 = c_drv;
        cyc();
        cyc();
        dl1_valid = 0; l2c_rv = 1;
        repeat (3) cyc();
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
        chk1 ("rst l2c_valid", s_lval, 1'b0);
        chk32("rst l2c_adr", s_adr, 32'h0);
        chk32("rst l2c_flags", 32'(s_flags), 32'h0);
        chk1 ("rst dl1_stall", s_dst, 1'b1);
        chk1 ("rst dl1 strobe dropped", s_drv, 1'b0);
        repeat (3) cyc();
        chk32("rst dl1 beat count", c_drv - base0, 4);

        // Randomized traffic; requesters hold valid until they see stall low.
        idle_inputs();
        pend_i = 0; pend_d = 0; s_ist = 1; s_dst = 1;
        for (int n = 0; n < 4000; n++) begin
            if (pend_i && !s_ist) pend_i = 0;
            else if (!pend_i && $urandom_range(0, 3) == 0) begin
                pend_i = 1; il1_adr = $urandom(); il1_flags = 2'($urandom_range(0, 3));
            end
            if (pend_d && !s_dst) pend_d = 0;
            else if (!pend_d && $urandom_range(0, 3) == 0) begin
                pend_d = 1; dl1_adr = $urandom(); dl1_flags = 2'($urandom_range(0, 3));
            end
            il1_valid = pend_i; dl1_valid = pend_d;
            l2c_stall = ($urandom_range(0, 2) == 0);
            l2c_rv    = ($urandom_range(0, 2) == 0);
            l2c_flt   = ($urandom_range(0, 40) == 0);
            l2c_rdata = $urandom();
            rst_n     = ($urandom_range(0, 300) != 0);
            inv_req   = ($urandom_range(0, 1) == 0);
            inv_adr   = $urandom();
            il1_ack   = ($urandom_range(0, 3) == 0);
            dl1_ack   = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
